plic_claim_ctrl: RTL and testbench
==================================

PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

Interface
REQ-001 Parameters SHALL be: SOURCES, default 8, number of interrupt sources; TARGETS, default 2, number of targets/contexts; SOURCES_BITS, default 4, ID width, at least clog2(SOURCES+1).
REQ-002 Ports SHALL be: rst_ni  in  1  asynchronous active-low reset.
REQ-003 clk_i  in  1  system clock, rising edge.
REQ-004 src_i  in  SOURCES  level-sensitive interrupt source lines, bit s = source ID s+1.
REQ-005 claim_i  in  TARGETS  one-cycle claim strobe per target.
REQ-006 claim_id_i  in  SOURCES_BITS x [TARGETS]  ID each target claims, taken from its target ID output.
REQ-007 complete_i  in  TARGETS  one-cycle completion strobe per target.
REQ-008 complete_id_i  in  SOURCES_BITS x [TARGETS]  ID each target completes.
REQ-009 pending_o  out  SOURCES  per-source pending bits, fed to the priority/target logic.
REQ-010 claim_ack_o  out  TARGETS  registered claim-response strobe.
REQ-011 claim_id_o  out  SOURCES_BITS x [TARGETS]  granted ID; 0 = no interrupt granted.

Function
REQ-012 Each source SHALL run a 3-state FSM: IDLE, PENDING, CLAIMED; pending_o[s] SHALL be 1 only in PENDING.
REQ-013 IDLE -> PENDING SHALL occur on the first rising clk_i edge with src_i[s]=1; there is no transition while src_i[s]=0.
REQ-014 PENDING -> CLAIMED SHALL occur on the edge where a claim for ID s+1 is granted; src_i is ignored in PENDING and CLAIMED.
REQ-015 CLAIMED -> IDLE SHALL occur on the edge where any target asserts complete_i with complete_id_i = s+1.
REQ-016 Completion SHALL be ignored for ID 0, for IDs > SOURCES, and for sources not in CLAIMED.
REQ-017 Claim response latency SHALL be one cycle: claim_ack_o[t] is high for exactly the cycle after claim_i[t].
REQ-018 The accompanying claim_id_o[t] SHALL be the claimed ID if granted, else 0.
REQ-019 A claim SHALL be granted only when its ID is 1..SOURCES and the source is PENDING at that edge; otherwise it SHALL be answered with ID 0 and no state change.
REQ-020 When several targets claim the same ID in one cycle, exactly one SHALL be granted per the arbitration of REQ-029/030; the losers SHALL get ID 0.
REQ-021 Claims of different IDs in the same cycle SHALL all be granted independently.
REQ-022 Claim and complete of the same ID in one cycle: completion acts on CLAIMED only, so the claim gets ID 0 and the source goes to IDLE.
REQ-023 Complete with src_i still high SHALL give IDLE for one cycle, then PENDING on the next edge, so there is exactly one cycle of pending_o=0.
REQ-024 claim_id_o[t] SHALL hold its last value while claim_ack_o[t]=0.

Reset
REQ-025 Asserting rst_ni low SHALL asynchronously force all sources to IDLE, pending_o=0, claim_ack_o=0, claim_id_o=0, and the round-robin pointer to target 0.
REQ-026 Reset mid-operation SHALL discard all claimed state; no completion is needed afterwards.
REQ-027 After release, the first state change SHALL occur on the first rising edge with rst_ni high.
REQ-028 All state SHALL be reset, including claim_id_o.

Configuration
REQ-029 With macro PLIC_CLAIM_RR_EN defined, same-ID claim conflicts SHALL be resolved round-robin.
  - The pointer advances to the target after the winner on each conflicted grant.
  - The pointer is unchanged when no conflict occurs.
REQ-030 Without PLIC_CLAIM_RR_EN, conflicts SHALL be resolved by fixed priority, lowest target index wins, and no pointer register exists.

Verification
REQ-031 Reset, then src_i[2]=1 -> pending_o[2]=1 one edge later; claim_i[0], ID 3 -> next cycle claim_ack_o[0]=1, claim_id_o[0]=3, pending_o[2]=0.
REQ-032 Source 3 CLAIMED, src_i[2] held 1, complete_i[0] with ID 3 -> pending_o[2]=0 for one cycle, then 1.
REQ-033 Targets 0 and 1 both claim ID 3, fixed priority -> target 0 gets 3, target 1 gets 0. Under PLIC_CLAIM_RR_EN, repeat twice -> winners alternate 0, then 1.
REQ-034 Claim ID 0, claim ID 9 (SOURCES=8), claim of an IDLE source -> claim_ack_o=1 with claim_id_o=0 and no pending_o change; completes of ID 0 and ID 9 -> no state change.
REQ-035 Source 5 CLAIMED, rst_ni pulsed low mid-cycle -> outputs 0 immediately without a clock edge; src_i[4]=1 after release -> pending_o[4]=1 one edge later.
REQ-036 Same-cycle claim and complete of ID 2 (CLAIMED) -> claim_id_o=0, source 2 IDLE.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: per-source IDLE/PENDING/CLAIMED gateway with registered claim responses.
// Define PLIC_CLAIM_RR_EN for round-robin same-ID claim arbitration (default: lowest target wins).
module plic_claim_ctrl #(
  parameter int SOURCES      = 8,
  parameter int TARGETS      = 2,
  parameter int SOURCES_BITS = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [SOURCES-1:0]                     src_i,
  input  logic [TARGETS-1:0]                     claim_i,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0]   claim_id_i,
  input  logic [TARGETS-1:0]                     complete_i,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0]   complete_id_i,
  output logic [SOURCES-1:0]                     pending_o,
  output logic [TARGETS-1:0]                     claim_ack_o,
  output logic [TARGETS-1:0][SOURCES_BITS-1:0]   claim_id_o
);
  typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} state_t;
  state_t st [SOURCES];
  logic [TARGETS-1:0] valid, win;
  logic [SOURCES-1:0] grant, done;
`ifdef PLIC_CLAIM_RR_EN
  localparam int PW = TARGETS > 1 ? $clog2(TARGETS) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [TARGETS-1:0] conf;
  logic upd;
  function automatic int rank(input int t, input int p);
    return t >= p ? t - p : t + TARGETS - p;
  endfunction
`endif
  // A claim is only valid against a PENDING source; out-of-range IDs never match any source.
  always_comb begin
    valid = '0;
    win = '0;
    grant = '0;
    done = '0;
`ifdef PLIC_CLAIM_RR_EN
    conf = '0;
    ptr_nxt = ptr;
    upd = 1'b0;
`endif
    for (int t = 0; t < TARGETS; t++)
      for (int s = 0; s < SOURCES; s++)
        if (claim_i[t] && int'(claim_id_i[t]) == s + 1 && st[s] == PENDING) valid[t] = 1'b1;
    for (int t = 0; t < TARGETS; t++) begin
      win[t] = valid[t];
      for (int u = 0; u < TARGETS; u++)
        if (u != t && valid[u] && claim_id_i[u] == claim_id_i[t]) begin
`ifdef PLIC_CLAIM_RR_EN
          conf[t] = 1'b1;
          if (rank(u, int'(ptr)) < rank(t, int'(ptr))) win[t] = 1'b0;
`else
          if (u < t) win[t] = 1'b0;
`endif
        end
`ifdef PLIC_CLAIM_RR_EN
      if (win[t] && conf[t] && !upd) begin
        ptr_nxt = PW'((t + 1) % TARGETS);
        upd = 1'b1;
      end
`endif
    end
    for (int t = 0; t < TARGETS; t++)
      for (int s = 0; s < SOURCES; s++) begin
        if (win[t] && int'(claim_id_i[t]) == s + 1) grant[s] = 1'b1;
        if (complete_i[t] && int'(complete_id_i[t]) == s + 1) done[s] = 1'b1;
      end
  end
  always_comb
    for (int s = 0; s < SOURCES; s++) pending_o[s] = st[s] == PENDING;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int s = 0; s < SOURCES; s++) st[s] <= IDLE;
      claim_ack_o <= '0;
      claim_id_o <= '0;
`ifdef PLIC_CLAIM_RR_EN
      ptr <= '0;
`endif
    end else begin
      for (int s = 0; s < SOURCES; s++)
        st[s] <= st[s] == IDLE    ? (src_i[s] ? PENDING : IDLE) :
                 st[s] == PENDING ? (grant[s] ? CLAIMED : PENDING) :
                                    (done[s]  ? IDLE    : CLAIMED);
      claim_ack_o <= claim_i;
      for (int t = 0; t < TARGETS; t++)
        if (claim_i[t]) claim_id_o[t] <= win[t] ? claim_id_i[t] : '0;
`ifdef PLIC_CLAIM_RR_EN
      ptr <= ptr_nxt;
`endif
    end
endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb_plic_claim_ctrl: table-driven directed checks plus async-reset sequence for plic_claim_ctrl.
module tb_plic_claim_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] src = '0;
  logic [1:0] clm = '0, cmp = '0, ack;
  logic [1:0][3:0] cid = '0, pid = '0, oid;
  logic [7:0] pend;
  int n_cmp = 0, n_bad = 0;

  plic_claim_ctrl #(.SOURCES(8), .TARGETS(2), .SOURCES_BITS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .claim_i(clm), .claim_id_i(cid),
    .complete_i(cmp), .complete_id_i(pid), .pending_o(pend), .claim_ack_o(ack), .claim_id_o(oid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] src;
    logic [1:0] clm;
    logic [3:0] c0, c1;
    logic [1:0] cmp;
    logic [3:0] p0, p1;
    logic [7:0] pend;
    logic [1:0] ack;
    logic [3:0] i0, i1;
  } vec_t;

`ifdef PLIC_CLAIM_RR_EN
  localparam logic [3:0] W0 = 4'd0, W1 = 4'd3;
`else
  localparam logic [3:0] W0 = 4'd3, W1 = 4'd0;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [1:0] cl, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [1:0] cp, input logic [3:0] p0, input logic [3:0] p1);
    src = s; clm = cl; cid[0] = c0; cid[1] = c1; cmp = cp; pid[0] = p0; pid[1] = p1;
    @(posedge clk);
    #1;
  endtask

  vec_t v [22];

  initial begin
    v[0]  = '{8'h04, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h04, 2'b00, 4'd0, 4'd0};
    v[1]  = '{8'h04, 2'b01, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0, 8'h00, 2'b01, 4'd3, 4'd0};
    v[2]  = '{8'h04, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h00, 2'b00, 4'd3, 4'd0};
    v[3]  = '{8'h04, 2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0, 8'h00, 2'b00, 4'd3, 4'd0};
    v[4]  = '{8'h04, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h04, 2'b00, 4'd3, 4'd0};
    v[5]  = '{8'h00, 2'b11, 4'd3, 4'd3, 2'b00, 4'd0, 4'd0, 8'h00, 2'b11, 4'd3, 4'd0};
    v[6]  = '{8'h00, 2'b00, 4'd0, 4'd0, 2'b10, 4'd0, 4'd3, 8'h00, 2'b00, 4'd3, 4'd0};
    v[7]  = '{8'h04, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h04, 2'b00, 4'd3, 4'd0};
    v[8]  = '{8'h00, 2'b11, 4'd3, 4'd3, 2'b00, 4'd0, 4'd0, 8'h00, 2'b11, W0, W1};
    v[9]  = '{8'h00, 2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0, 8'h00, 2'b00, W0, W1};
    v[10] = '{8'h00, 2'b11, 4'd0, 4'd9, 2'b00, 4'd0, 4'd0, 8'h00, 2'b11, 4'd0, 4'd0};
    v[11] = '{8'h00, 2'b01, 4'd5, 4'd0, 2'b00, 4'd0, 4'd0, 8'h00, 2'b01, 4'd0, 4'd0};
    v[12] = '{8'h02, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h02, 2'b00, 4'd0, 4'd0};
    v[13] = '{8'h00, 2'b00, 4'd0, 4'd0, 2'b11, 4'd0, 4'd9, 8'h02, 2'b00, 4'd0, 4'd0};
    v[14] = '{8'h00, 2'b10, 4'd0, 4'd2, 2'b00, 4'd0, 4'd0, 8'h00, 2'b10, 4'd0, 4'd2};
    v[15] = '{8'h00, 2'b01, 4'd2, 4'd0, 2'b10, 4'd0, 4'd2, 8'h00, 2'b01, 4'd0, 4'd2};
    v[16] = '{8'h02, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h02, 2'b00, 4'd0, 4'd2};
    v[17] = '{8'h03, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h03, 2'b00, 4'd0, 4'd2};
    v[18] = '{8'h00, 2'b11, 4'd1, 4'd2, 2'b00, 4'd0, 4'd0, 8'h00, 2'b11, 4'd1, 4'd2};
    v[19] = '{8'h00, 2'b00, 4'd0, 4'd0, 2'b11, 4'd1, 4'd2, 8'h00, 2'b00, 4'd1, 4'd2};
    v[20] = '{8'h01, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 8'h01, 2'b00, 4'd1, 4'd2};
    v[21] = '{8'h00, 2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0, 8'h01, 2'b00, 4'd1, 4'd2};

    #12;
    chk("reset_pend", pend, 8'h00);
    chk("reset_ack", {6'd0, ack}, 8'h00);
    chk("reset_id", oid, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(v[i].src, v[i].clm, v[i].c0, v[i].c1, v[i].cmp, v[i].p0, v[i].p1);
      chk($sformatf("v%0d_pend", i), pend, v[i].pend);
      chk($sformatf("v%0d_ack", i), {6'd0, ack}, {6'd0, v[i].ack});
      chk($sformatf("v%0d_id0", i), {4'd0, oid[0]}, {4'd0, v[i].i0});
      chk($sformatf("v%0d_id1", i), {4'd0, oid[1]}, {4'd0, v[i].i1});
    end

    // Claim source 5, then reset mid-cycle and expect immediate clearing.
    drive(8'h10, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0);
    chk("s5_pend", pend, 8'h11);
    drive(8'h00, 2'b01, 4'd5, 4'd0, 2'b00, 4'd0, 4'd0);
    chk("s5_claim", {4'd0, oid[0]}, 8'd5);
    chk("s5_ack", {6'd0, ack}, 8'h01);
    src = 8'h10; clm = '0; cmp = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pend", pend, 8'h00);
    chk("async_ack", {6'd0, ack}, 8'h00);
    chk("async_id", oid, 8'h00);
    @(posedge clk);
    #1;
    chk("held_pend", pend, 8'h00);
    rst_n = 1'b1;
    chk("rel_pend", pend, 8'h00);
    @(posedge clk);
    #1;
    chk("rel_edge_pend", pend, 8'h10);
    drive(8'h00, 2'b10, 4'd0, 4'd5, 2'b00, 4'd0, 4'd0);
    chk("rel_claim", {4'd0, oid[1]}, 8'd5);
    chk("rel_claim_pend", pend, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
